prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_pkg.sv | 16 +
 rtl/prog_clk_div.sv | 30 +++
 rtl/prog_loader.sv | 180 ++++++++++++++++++
 tb/tb_prog_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
package prog_pkg;

    localparam int unsigned DEF_CHAIN_LEN = 64;
    localparam int unsigned DEF_CLK_DIV   = 2;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        FINISH
    } state_t;

endpackage

// File: rtl/prog_clk_div.sv
// Phase timer: flags the last clk cycle of each CLK_DIV-long prog_clk phase.
module prog_clk_div
    import prog_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic phase_end_c
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign phase_end_c = run && (cnt == CW'(CLK_DIV - 1));

    // Restarts from zero at every phase boundary and whenever the loader is not shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || phase_end_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial configuration-chain loader: bytes in, LSB-first bit stream out on prog_in/prog_clk.
// Define PROG_LOADER_READBACK_EN to add rb_data/rb_valid capture of prog_out.
module prog_loader
    import prog_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              prog_out,
    output logic              prog_in,
    output logic              prog_clk,
    output logic              prog_en,
    output logic              busy,
`ifdef PROG_LOADER_READBACK_EN
    output logic [BYTE_W-1:0] rb_data,
    output logic              rb_valid,
`endif
    output logic              done
);

    localparam int unsigned BCW = $clog2(CHAIN_LEN + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);

    state_t            state, state_d;
    logic [BYTE_W-1:0] shreg, shreg_d;
    logic [BCW-1:0]    bit_cnt, bit_cnt_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic              phase_end_c;
    logic              shifting_c;
    logic              data_ready_d, prog_in_d, prog_clk_d, prog_en_d, busy_d, done_d;

    assign shifting_c = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == FINISH);

    prog_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk         (clk),
        .rst         (rst),
        .run         (shifting_c),
        .phase_end_c (phase_end_c)
    );

    // Next-state logic; outputs are derived from the next state so they line up with it.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        bit_idx_d = bit_idx;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = FETCH;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            FETCH: begin
                if (data_valid) begin
                    state_d   = SHIFT_LO;
                    shreg_d   = data_in;
                    bit_idx_d = '0;
                end
            end
            SHIFT_LO: begin
                if (phase_end_c) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end_c) begin
                    bit_cnt_d = bit_cnt + BCW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_d = FINISH;
                    end else if (bit_idx == 3'd7) begin
                        state_d = FETCH;
                    end else begin
                        state_d   = SHIFT_LO;
                        shreg_d   = shreg >> 1;
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            FINISH: begin
                if (phase_end_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        data_ready_d = (state_d == FETCH);
        busy_d       = (state_d != IDLE);
        prog_en_d    = busy_d;
        prog_clk_d   = (state_d == SHIFT_HI);
        // Data only moves on the low phase; otherwise it holds, and parks at 0 when idle.
        if (state_d == SHIFT_LO) begin
            prog_in_d = shreg_d[0];
        end else if (state_d == IDLE) begin
            prog_in_d = 1'b0;
        end else begin
            prog_in_d = prog_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            data_ready <= 1'b0;
            prog_in    <= 1'b0;
            prog_clk   <= 1'b0;
            prog_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            bit_cnt    <= bit_cnt_d;
            bit_idx    <= bit_idx_d;
            data_ready <= data_ready_d;
            prog_in    <= prog_in_d;
            prog_clk   <= prog_clk_d;
            prog_en    <= prog_en_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef PROG_LOADER_READBACK_EN
    logic [BYTE_W-1:0] rb_acc;
    logic [BYTE_W-1:0] rb_byte_c;
    logic              rb_sample_c;

    // prog_out is sampled in the cycle whose edge raises prog_clk.
    assign rb_sample_c = (state == SHIFT_LO) && phase_end_c && !abort;
    assign rb_byte_c   = rb_acc | (BYTE_W'(prog_out) << bit_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_acc   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == IDLE) begin
                rb_acc <= '0;
            end else if (rb_sample_c) begin
                if ((bit_idx == 3'd7) || (bit_cnt == LAST_BIT)) begin
                    rb_data  <= rb_byte_c;
                    rb_valid <= 1'b1;
                    rb_acc   <= '0;
                end else begin
                    rb_acc <= rb_byte_c;
                end
            end
        end
    end
`else
    logic unused_prog_out;
    assign unused_prog_out = prog_out;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a 16-bit and a 10-bit chain instance with simple chain models.
`timescale 1ns/1ps
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b, abort, data_valid;
    logic [7:0] data_in;

    logic data_ready_a, prog_in_a, prog_clk_a, prog_en_a, busy_a, done_a, prog_out_a;
    logic data_ready_b, prog_in_b, prog_clk_b, prog_en_b, busy_b, done_b, prog_out_b;
`ifdef PROG_LOADER_READBACK_EN
    logic [7:0] rb_data_a, rb_data_b;
    logic       rb_valid_a, rb_valid_b;
`endif

    always #5 clk = ~clk;

    prog_loader #(.CHAIN_LEN(16), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready_a),
        .prog_out(prog_out_a), .prog_in(prog_in_a), .prog_clk(prog_clk_a),
        .prog_en(prog_en_a), .busy(busy_a),
`ifdef PROG_LOADER_READBACK_EN
        .rb_data(rb_data_a), .rb_valid(rb_valid_a),
`endif
        .done(done_a)
    );

    prog_loader #(.CHAIN_LEN(10), .CLK_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready_b),
        .prog_out(prog_out_b), .prog_in(prog_in_b), .prog_clk(prog_clk_b),
        .prog_en(prog_en_b), .busy(busy_b),
`ifdef PROG_LOADER_READBACK_EN
        .rb_data(rb_data_b), .rb_valid(rb_valid_b),
`endif
        .done(done_b)
    );

    // Chain models: shift on prog_clk rise, last cell drives prog_out.
    logic [15:0] chain_a = '0;
    logic [9:0]  chain_b = '0;
    always @(posedge prog_clk_a) chain_a <= {prog_in_a, chain_a[15:1]};
    always @(posedge prog_clk_b) chain_b <= {prog_in_b, chain_b[9:1]};
    assign prog_out_a = chain_a[0];
    assign prog_out_b = chain_b[0];

    int   rises_a = 0, rises_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int   viol_a = 0, viol_b = 0;
    logic bits_a [0:511];
    logic bits_b [0:511];
    logic pin_prev_a = 1'b0, pclk_prev_a = 1'b0, pin_prev_b = 1'b0, pclk_prev_b = 1'b0;

    always @(posedge prog_clk_a) begin
        if (rises_a < 512) bits_a[rises_a] <= prog_in_a;
        rises_a <= rises_a + 1;
    end
    always @(posedge prog_clk_b) begin
        if (rises_b < 512) bits_b[rises_b] <= prog_in_b;
        rises_b <= rises_b + 1;
    end
    always @(posedge clk) begin
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    end
    // prog_in must never move across a cycle where prog_clk stays high.
    always @(negedge clk) begin
        if (prog_in_a !== pin_prev_a && prog_clk_a === 1'b1 && pclk_prev_a === 1'b1) viol_a <= viol_a + 1;
        if (prog_in_b !== pin_prev_b && prog_clk_b === 1'b1 && pclk_prev_b === 1'b1) viol_b <= viol_b + 1;
        pin_prev_a  <= prog_in_a;
        pclk_prev_a <= prog_clk_a;
        pin_prev_b  <= prog_in_b;
        pclk_prev_b <= prog_clk_b;
    end

`ifdef PROG_LOADER_READBACK_EN
    int         rb_n = 0;
    logic [7:0] rb_log [0:63];
    always @(posedge clk) begin
        if (rb_valid_a === 1'b1) begin
            if (rb_n < 64) rb_log[rb_n] <= rb_data_a;
            rb_n <= rb_n + 1;
        end
    end
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic feed(input int which, input logic [7:0] b);
        int t = 0;
        while (((which == 0) ? data_ready_a : data_ready_b) !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            check("feed_timeout", 32'd0, 32'd1);
        end else begin
            data_in    = b;
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int which, input string tag);
        int   t = 0;
        logic seen = 1'b0;
        while (!seen && t < 400) begin
            tick();
            t++;
            if (((which == 0) ? done_a : done_b) === 1'b1) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] get_bits(input int which, input int base, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = (which == 0) ? bits_a[base + i] : bits_b[base + i];
        return v;
    endfunction

    initial begin
        int rb0, db0, stall_bad, t;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        data_valid = 1'b0; data_in = '0;
        #23;
        check("rst_busy",       32'(busy_a),       32'd0);
        check("rst_prog_en",    32'(prog_en_a),    32'd0);
        check("rst_prog_clk",   32'(prog_clk_a),   32'd0);
        check("rst_data_ready", 32'(data_ready_a), 32'd0);
        check("rst_done",       32'(done_a),       32'd0);
        check("rst_prog_in",    32'(prog_in_a),    32'd0);
        rst = 1'b0;
        tick();

        // 16-bit load of A5,3C with a 20-cycle stall between bytes.
        rb0 = rises_a; db0 = done_cnt_a;
        pulse_start(0);
        check("start_busy",  32'(busy_a),       32'd1);
        check("start_ready", 32'(data_ready_a), 32'd1);
        feed(0, 8'hA5);
        t = 0;
        while (data_ready_a !== 1'b1 && t < 200) begin tick(); t++; end
        check("byte0_rises", 32'(rises_a - rb0), 32'd8);
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            start_a = (i == 5);
            if (prog_en_a !== 1'b1 || prog_clk_a !== 1'b0) stall_bad++;
            tick();
        end
        start_a = 1'b0;
        check("stall_levels", 32'(stall_bad), 32'd0);
        check("stall_rises",  32'(rises_a - rb0), 32'd8);
        check("stall_ready",  32'(data_ready_a), 32'd1);
        feed(0, 8'h3C);
        wait_done(0, "a16_done_seen");
        tick();
        check("a16_rises",   32'(rises_a - rb0), 32'd16);
        check("a16_bits",    get_bits(0, rb0, 16), 32'h3CA5);
        check("a16_done_n",  32'(done_cnt_a - db0), 32'd1);
        check("a16_busy",    32'(busy_a), 32'd0);
        check("a16_prog_en", 32'(prog_en_a), 32'd0);

        // 10-bit chain: upper six bits of the second byte are dropped.
        rb0 = rises_b; db0 = done_cnt_b;
        pulse_start(1);
        feed(1, 8'hFF);
        feed(1, 8'h02);
        wait_done(1, "b10_done_seen");
        repeat (10) tick();
        check("b10_rises",  32'(rises_b - rb0), 32'd10);
        check("b10_bits",   get_bits(1, rb0, 10), 32'h2FF);
        check("b10_done_n", 32'(done_cnt_b - db0), 32'd1);
        check("b10_ready",  32'(data_ready_b), 32'd0);

        // start with abort in IDLE is ignored.
        start_a = 1'b1; abort = 1'b1;
        tick();
        start_a = 1'b0; abort = 1'b0;
        tick();
        check("idle_start_abort_busy", 32'(busy_a), 32'd0);

        // Abort after the 5th rising edge, then a clean reload.
        rb0 = rises_a; db0 = done_cnt_a;
        pulse_start(0);
        feed(0, 8'hFF);
        t = 0;
        while ((rises_a - rb0) < 5 && t < 200) begin tick(); t++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_prog_en",  32'(prog_en_a),  32'd0);
        check("abort_busy",     32'(busy_a),     32'd0);
        check("abort_prog_clk", 32'(prog_clk_a), 32'd0);
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt_a - db0), 32'd0);
        check("abort_rises",   32'(rises_a - rb0), 32'd5);
        rb0 = rises_a; db0 = done_cnt_a;
        pulse_start(0);
        feed(0, 8'h12);
        feed(0, 8'h34);
        wait_done(0, "reload_done_seen");
        tick();
        check("reload_bits",  get_bits(0, rb0, 16), 32'h3412);
        check("reload_rises", 32'(rises_a - rb0), 32'd16);

        // Asynchronous reset during the high phase.
        pulse_start(0);
        feed(0, 8'h81);
        t = 0;
        while (prog_clk_a !== 1'b1 && t < 200) begin tick(); t++; end
        #2 rst = 1'b1;
        #1;
        check("arst_prog_clk", 32'(prog_clk_a), 32'd0);
        check("arst_prog_en",  32'(prog_en_a),  32'd0);
        check("arst_busy",     32'(busy_a),     32'd0);
        #1 rst = 1'b0;
        tick();
        check("viol_a", 32'(viol_a), 32'd0);
        check("viol_b", 32'(viol_b), 32'd0);

`ifdef PROG_LOADER_READBACK_EN
        // Preload 5A,C3 into the chain model, then read it back while loading zeros.
        pulse_start(0);
        feed(0, 8'h5A);
        feed(0, 8'hC3);
        wait_done(0, "pre_done_seen");
        rb0 = rb_n;
        pulse_start(0);
        feed(0, 8'h00);
        feed(0, 8'h00);
        wait_done(0, "rb_done_seen");
        tick();
        check("rb_count", 32'(rb_n - rb0), 32'd2);
        check("rb_byte0", 32'(rb_log[rb0]), 32'h5A);
        check("rb_byte1", 32'(rb_log[rb0 + 1]), 32'hC3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
